// File: rtl/hs_stream_src_pkg.sv
// rtl/hs_stream_src_pkg.sv - shared state enum, stall counter width and reset pattern for hs_stream_src
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int STALL_W = 16;

  // Power-on content of table entry i; callers truncate to their beat width.
  function automatic int reset_pattern(input int i);
    return i;
  endfunction

endpackage

// File: rtl/hs_stream_src_if.sv
// rtl/hs_stream_src_if.sv - valid/ready/last beat channel between hs_stream_src and its slave
interface hs_stream_src_if #(
  parameter int DATA_W = 8
);
  logic              valid_up;
  logic [DATA_W-1:0] data_up;
  logic              last_up;
  logic              ready_up;

  modport master (output valid_up, data_up, last_up, input ready_up);
  modport slave  (input valid_up, data_up, last_up, output ready_up);
endinterface

// File: rtl/hs_pattern_ram.sv
// rtl/hs_pattern_ram.sv - DEPTH x DATA_W pattern table, sync write, comb read, reset to entry i = i
module hs_pattern_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  import hs_pkg::*;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Table storage: reload the ramp pattern on reset, otherwise take writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(reset_pattern(i));
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A same-cycle write is not seen here, so a concurrent load gets the old value.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hs_stream_src.sv
// rtl/hs_stream_src.sv - table-driven burst stream source; HS_SRC_STALL_CNT_EN enables the stall counter
module hs_stream_src #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH),
  parameter int LEN_W  = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [DATA_W-1:0]          cfg_wdata,
  input  logic                       start,
  input  logic [AW-1:0]              start_idx,
  input  logic [LEN_W-1:0]           burst_len,
  hs_stream_src_if.master            up,
  output logic                       busy,
  output logic                       done,
  output logic [hs_pkg::STALL_W-1:0] stall_cnt
);
  import hs_pkg::*;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              xfer;

  hs_pattern_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign xfer = valid_q && up.ready_up;

  // State, burst position and the registered output beat.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // Next state, table read address and next beat; the beat only changes on acceptance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    rd_addr = idx_q + AW'(1);
    case (state_q)
      IDLE: begin
        rd_addr = start_idx;
        if (start) begin
          idx_d = start_idx;
          rem_d = burst_len;
          if (burst_len == '0) begin
            state_d = DONE;
          end else begin
            valid_d = 1'b1;
            data_d  = rd_data;
            last_d  = (burst_len == LEN_W'(1));
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (xfer) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            idx_d  = idx_q + AW'(1);
            rem_d  = rem_q - LEN_W'(1);
            data_d = rd_data;
            last_d = (rem_q == LEN_W'(2));
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign up.valid_up = valid_q;
  assign up.data_up  = data_q;
  assign up.last_up  = last_q;
  assign busy        = (state_q == SEND);
  assign done        = (state_q == DONE);

`ifdef HS_SRC_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q;

  // Backpressure cycles of the current or most recent burst, saturating.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start) begin
      stall_q <= '0;
    end else if (valid_q && !up.ready_up && stall_q != '1) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/hs_stream_src.md
# hs_stream_src

Parameterised valid/ready stream source for the bus-handshake lab. It holds a DEPTH-entry pattern table, writable at run time, and plays a burst of programmable length from a programmable start index, wrapping around the table. It drives a registered valid/data/last channel that obeys strict hold-under-backpressure rules. It sits upstream of any ready-driven slave and replaces fixed-pattern, unregistered sources.

## Interface
- DATA_W, 8: beat width in bits
- DEPTH, 4: pattern table entries (power of two, ≥2)
- AW, $clog2(DEPTH): table index width (derived)
- LEN_W, 8: burst length field width
- sys_clk  in  1  single clock; all logic on its rising edge
- sys_rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  table write index
- cfg_wdata  in  DATA_W  table write data
- start  in  1  one-cycle burst request
- start_idx  in  AW  first table index of the burst
- burst_len  in  LEN_W  beats in burst (0 = empty burst)
- ready_up  in  1  downstream ready
- valid_up  out  1  beat valid (registered)
- data_up  out  DATA_W  beat data (registered)
- last_up  out  1  final beat of burst (registered)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- stall_cnt  out  16  backpressure cycles in current/last burst (see Configuration)

## Operation
- States: IDLE, SEND, DONE.
- IDLE: busy=0. On start, latch idx=start_idx and rem=burst_len.
  - If burst_len=0: go to DONE, no beats issued.
  - Otherwise: load the output register with table[start_idx], set valid_up=1, set last_up=(burst_len==1), go to SEND.
- SEND: busy=1. A beat transfers on valid_up && ready_up.
  - On a transfer with rem>1: idx=idx+1 mod DEPTH (natural AW-bit wrap), rem=rem-1. Load table[new idx] into the output register the same cycle. last_up=(rem-1==1).
  - On a transfer with last_up=1: valid_up=0, last_up=0, go to DONE.
  - While valid_up && !ready_up: data_up, last_up and valid_up hold unchanged. valid_up never drops before its beat is accepted.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- start outside IDLE is ignored. start and the final transfer in the same cycle: start is ignored.
- The table is written on cfg_we in any state and becomes visible the next cycle.
  - A write never alters a beat already in the output register.
  - A write to the index being loaded in the same cycle: the old value is loaded.
- After reset, table[i]=i truncated to DATA_W.
- data_up holds its last value when valid_up=0. It is 0 only after reset.

## Timing
- Reset values: valid_up=0, data_up=0, last_up=0, busy=0, done=0, stall_cnt=0, state=IDLE.
- Reset asserted mid-burst aborts the burst with no done pulse. Outputs take reset values the following cycle.
- Latency from start (cycle N) to first valid_up: N+1.
- Throughput: one beat per cycle with ready_up held high.
- Burst of L beats with no stall: valid_up high N+1..N+L, done at N+L+1.
- Empty burst: done at N+1, valid_up never asserted.
- Back-to-back bursts: start is accepted at the earliest in the cycle after done, which is the first IDLE cycle.

## Configuration
- HS_SRC_STALL_CNT_EN defined:
  - stall_cnt increments each cycle with valid_up && !ready_up.
  - It saturates at 16'hFFFF.
  - It clears on an accepted start and holds after done until the next accepted start.
- Not defined: stall_cnt is tied to 0 and no counter logic is present. The port remains so the instance wiring is unchanged.

## Structure
- Shared package hs_pkg holds:
  - the state enum (IDLE/SEND/DONE);
  - the stall counter width constant (16);
  - the reset-pattern function (entry i → i).
- One sub-module, hs_pattern_ram: DEPTH×DATA_W table with synchronous write, combinational read and reset initialisation. All FSM, counters and the output register live in hs_stream_src.

## Test plan
- Reset, then start with start_idx=0, burst_len=3, ready_up=1 → data_up 0,1,2 on cycles N+1..N+3, last_up on the third beat, done at N+4.
- DEPTH=4, start_idx=3, burst_len=6 → data sequence 3,0,1,2,3,0, showing the wrap.
- Same burst with ready_up low for 2 cycles on beat 2 → data_up/last_up stable while stalled, no beat lost or duplicated. With the macro defined, stall_cnt=2 after done.
- burst_len=0 → done at N+1, valid_up stays 0. A start issued during SEND is ignored, with beat count unchanged.
- Write table[1]=8'hA5 via cfg_we mid-burst while beat 1 waits under backpressure → the held beat keeps its old value. The next burst reads 8'hA5.
- Assert sys_rst in mid-burst → all outputs return to reset values the next cycle, with no done pulse. A subsequent burst runs normally from the reset pattern.
